// File: rtl/truth_table_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner_if
// Description : Bundle between the scanner (master) and the function block or
//               controller (slave). The ones count exists only with TT_ONES_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_scanner_if #(
    parameter int N = 3
);
    logic              start;
    logic              f_in;
    logic [N-1:0]      w_out;
    logic [(2**N)-1:0] tt;
    logic              busy;
    logic              done;
`ifdef TT_ONES_COUNT_EN
    logic [N:0]        ones;

    modport master (input start, f_in, output w_out, tt, busy, done, ones);
    modport slave  (output start, f_in, input w_out, tt, busy, done, ones);
`else
    modport master (input start, f_in, output w_out, tt, busy, done);
    modport slave  (output start, f_in, input w_out, tt, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Steps a code through 0..2^N-1, samples f_in at the end of each
//               hold and builds a truth table. TT_ONES_COUNT_EN adds a popcount.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner #(
    parameter int N      = 3,
    parameter int SETTLE = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    truth_table_scanner_if.master scan_if
);
    localparam int CODES = 2**N;
    localparam int HW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int OW    = N + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     w_q, w_d;
    logic [CODES-1:0] tt_q, tt_d;
    logic [HW-1:0]    hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        tt_d    = tt_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (scan_if.start) begin
                    state_d = S_SCAN;
                    w_d     = '0;
                    tt_d    = '0;
                    hold_d  = '0;
                end
            end
            S_SCAN: begin
                // Only the last cycle of each hold is sampled, so settle glitches never land in tt.
                if (hold_q == HW'(SETTLE)) begin
                    tt_d[w_q] = scan_if.f_in;
                    hold_d    = '0;
                    if (w_q == N'(CODES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        w_d = w_q + N'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            tt_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            tt_q    <= tt_d;
            hold_q  <= hold_d;
        end
    end

    assign scan_if.w_out = w_q;
    assign scan_if.tt    = tt_q;
    assign scan_if.busy  = (state_q == S_SCAN);
    assign scan_if.done  = (state_q == S_DONE);

`ifdef TT_ONES_COUNT_EN
    logic [N:0] ones_q, ones_d;

    function automatic logic [N:0] popcount(input logic [CODES-1:0] v);
        logic [N:0] cnt;
        cnt = '0;
        for (int i = 0; i < CODES; i++) begin
            cnt = cnt + OW'(v[i]);
        end
        return cnt;
    endfunction

    // Counted from the table as it will stand after the final sample, so it is valid alongside done.
    always_comb begin
        ones_d = ones_q;
        if ((state_q == S_IDLE) && scan_if.start) begin
            ones_d = '0;
        end else if ((state_q == S_SCAN) && (state_d == S_DONE)) begin
            ones_d = popcount(tt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign scan_if.ones = ones_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_scanner
// Description : Scoreboard bench: stimulus queues expected tables and done
//               cycles, a monitor per instance checks them on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fm0 = 0;      // 0 = majority, 1 = tied high, 2 = tied low
    int   cnt1 = 0;     // position within the current hold of the SETTLE=2 instance

    typedef struct {
        logic [7:0] tt;
        logic [3:0] ones;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    truth_table_scanner_if #(.N(3)) ifc0 ();
    truth_table_scanner_if #(.N(3)) ifc1 ();

    truth_table_scanner #(.N(3), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .scan_if(ifc0));
    truth_table_scanner #(.N(3), .SETTLE(2)) dut1 (.clk(clk), .rst(rst), .scan_if(ifc1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic maj(input logic [2:0] w);
        return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    endfunction

    assign ifc0.f_in = (fm0 == 1) ? 1'b1 : (fm0 == 2) ? 1'b0 : maj(ifc0.w_out);

    // Wrong value in the first two cycles of every hold, correct only in the sampled cycle.
    always @(posedge clk) cnt1 <= ifc1.busy ? cnt1 + 1 : 0;
    assign ifc1.f_in = maj(ifc1.w_out) ^ ((cnt1 % 3) < 2);

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push0(input logic [7:0] tt, input logic [3:0] ones, input int c);
        exp_t e;
        e.tt = tt; e.ones = ones; e.cyc = c;
        q0.push_back(e);
    endtask

    task automatic go0(output int k);
        ifc0.start = 1'b1;
        @(negedge clk);
        ifc0.start = 1'b0;
        k = cyc;
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (ifc0.done) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("tt0", int'(ifc0.tt), int'(e.tt));
                chk("done_cycle0", cyc, e.cyc);
`ifdef TT_ONES_COUNT_EN
                chk("ones0", int'(ifc0.ones), int'(e.ones));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (ifc1.done) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("tt1", int'(ifc1.tt), int'(e.tt));
                chk("done_cycle1", cyc, e.cyc);
`ifdef TT_ONES_COUNT_EN
                chk("ones1", int'(ifc1.ones), int'(e.ones));
`endif
            end
        end
    end

    initial begin : stim
        int   k;
        exp_t e;
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_w0", int'(ifc0.w_out), 0);
        chk("rst_tt0", int'(ifc0.tt), 0);
        chk("rst_busy0", int'(ifc0.busy), 0);
        chk("rst_done0", int'(ifc0.done), 0);
        chk("rst_tt1", int'(ifc1.tt), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single majority scan, one code per cycle.
        fm0 = 0;
        go0(k);
        push0(8'hE8, 4'd4, k + 8);
        for (int i = 0; i < 8; i++) begin
            chk("w_step", int'(ifc0.w_out), i);
            chk("busy_scan", int'(ifc0.busy), 1);
            chk("done_low", int'(ifc0.done), 0);
            @(negedge clk);
        end
        chk("busy_after", int'(ifc0.busy), 0);
        repeat (3) @(negedge clk);

        // SETTLE=2 instance, glitching f_in during settle.
        ifc1.start = 1'b1;
        @(negedge clk);
        ifc1.start = 1'b0;
        k = cyc;
        e.tt = 8'hE8; e.ones = 4'd4; e.cyc = k + 24;
        q1.push_back(e);
        for (int j = 0; j < 24; j++) begin
            chk("w_hold1", int'(ifc1.w_out), j / 3);
            @(negedge clk);
        end
        chk("busy_after1", int'(ifc1.busy), 0);
        repeat (3) @(negedge clk);

        // Start re-pulsed during SCAN and DONE is ignored.
        go0(k);
        push0(8'hE8, 4'd4, k + 8);
        for (int j = 1; j <= 11; j++) begin
            ifc0.start = (j == 3 || j == 8 || j == 9);
            @(negedge clk);
        end
        ifc0.start = 1'b0;
        chk("no_requeue_busy", int'(ifc0.busy), 0);
        chk("w_held_last", int'(ifc0.w_out), 7);
        chk("tt_held", int'(ifc0.tt), 8'hE8);
        go0(k);
        chk("restart_busy", int'(ifc0.busy), 1);
        push0(8'hE8, 4'd4, k + 8);
        repeat (10) @(negedge clk);

        // Reset in the middle of a scan that has already captured ones.
        fm0 = 1;
        go0(k);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(ifc0.busy), 0);
        chk("midrst_w", int'(ifc0.w_out), 0);
        chk("midrst_tt", int'(ifc0.tt), 0);
        chk("midrst_done", int'(ifc0.done), 0);
        fm0 = 0;
        go0(k);
        push0(8'hE8, 4'd4, k + 8);
        repeat (10) @(negedge clk);

        // Constant functions.
        fm0 = 1;
        go0(k);
        push0(8'hFF, 4'd8, k + 8);
        repeat (10) @(negedge clk);
        fm0 = 2;
        go0(k);
        push0(8'h00, 4'd0, k + 8);
        repeat (10) @(negedge clk);

        // Start held high: a done every 10 cycles.
        fm0 = 0;
        ifc0.start = 1'b1;
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < 3; i++) push0(8'hE8, 4'd4, k + 8 + 10 * i);
        repeat (29) @(negedge clk);
        ifc0.start = 1'b0;
        repeat (12) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
